keccak_squeeze_serializer: RTL and testbench

- Reader on the output side of the permutation datapath.
- Captures a full 5x5x64 Keccak state, indexed [x][y][z] exactly as the step modules output it.
- Streams the rate lanes out one 64-bit lane per handshake, for SHA-3/SHAKE squeeze.
- When a request needs more lanes than one rate block holds, it requests further permuted states until the requested lane count has been delivered.

---
 rtl/keccak_squeeze_serializer.sv | 130 +++++++++++++
 tb/tb_keccak_squeeze_serializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeeze_serializer.sv
// Captures a permuted 5x5x64 Keccak state and streams its rate lanes, one lane per handshake, re-requesting states until the lane count is met.
// Optional SQUEEZE_ZEROIZE_EN clears the capture register and lane_o at block/request exit.
module keccak_squeeze_serializer #(
  parameter int RATE_LANES = 17,
  parameter int LEN_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [LEN_W-1:0]         req_lanes_i,
  input  logic                     state_valid_i,
  output logic                     state_ready_o,
  input  logic [4:0][4:0][63:0]    state_array_in,
  output logic [63:0]              lane_o,
  output logic                     lane_valid_o,
  input  logic                     lane_ready_i,
  output logic                     lane_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {IDLE, WAIT_STATE, STREAM} state_t;

  localparam logic [4:0]       LAST_IDX = 5'(RATE_LANES - 1);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  state_t                  state;
  logic [LEN_W-1:0]        remaining;
  logic [4:0]              lane_idx;
  logic [2:0]              lane_x;
  logic [2:0]              lane_y;
  logic [4:0][4:0][63:0]   cap;

  logic [2:0]              nx_x;
  logic [2:0]              nx_y;
  logic [LEN_W-1:0]        rem_dec;
  logic                    accept;

  // x/y counters track lane_idx so the [i mod 5][i div 5] lookup needs no divider
  always_comb begin
    nx_x = lane_x + 3'd1;
    nx_y = lane_y;
    if (lane_x == 3'd4) begin
      nx_x = 3'd0;
      nx_y = lane_y + 3'd1;
    end
  end

  assign rem_dec = (remaining != '0) ? (remaining - ONE) : '0;
  assign accept  = (state == STREAM) && lane_valid_o && lane_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      remaining     <= '0;
      lane_idx      <= '0;
      lane_x        <= '0;
      lane_y        <= '0;
      cap           <= '0;
      lane_o        <= '0;
      lane_valid_o  <= 1'b0;
      lane_last_o   <= 1'b0;
      state_ready_o <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (req_lanes_i != '0) begin
              remaining     <= req_lanes_i;
              state         <= WAIT_STATE;
              state_ready_o <= 1'b1;
              busy_o        <= 1'b1;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        WAIT_STATE: begin
          if (state_valid_i && state_ready_o) begin
            cap           <= state_array_in;
            lane_idx      <= '0;
            lane_x        <= '0;
            lane_y        <= '0;
            lane_o        <= state_array_in[0][0];
            lane_valid_o  <= 1'b1;
            lane_last_o   <= (remaining == ONE);
            state_ready_o <= 1'b0;
            state         <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            remaining <= rem_dec;
            lane_idx  <= lane_idx + 5'd1;
            if (rem_dec == '0) begin
              state        <= IDLE;
              lane_valid_o <= 1'b0;
              lane_last_o  <= 1'b0;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
`ifdef SQUEEZE_ZEROIZE_EN
              cap          <= '0;
              lane_o       <= '0;
`endif
            end else if (lane_idx == LAST_IDX) begin
              state         <= WAIT_STATE;
              lane_valid_o  <= 1'b0;
              lane_last_o   <= 1'b0;
              state_ready_o <= 1'b1;
`ifdef SQUEEZE_ZEROIZE_EN
              cap           <= '0;
              lane_o        <= '0;
`endif
            end else begin
              lane_x      <= nx_x;
              lane_y      <= nx_y;
              lane_o      <= cap[nx_x][nx_y];
              lane_last_o <= (rem_dec == ONE);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
// Directed scoreboard bench for keccak_squeeze_serializer (RATE_LANES=17).
module tb_keccak_squeeze_serializer;

  localparam int RATE  = 17;
  localparam int LEN_W = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  start_i;
  logic [LEN_W-1:0]      req_lanes_i;
  logic                  state_valid_i;
  logic                  state_ready_o;
  logic [4:0][4:0][63:0] state_array_in;
  logic [63:0]           lane_o;
  logic                  lane_valid_o;
  logic                  lane_ready_i;
  logic                  lane_last_o;
  logic                  busy_o;
  logic                  done_o;

  int passed = 0;
  int total  = 0;
  logic [63:0] q[$];
  logic [63:0] last_lane = '0;

  keccak_squeeze_serializer #(.RATE_LANES(RATE), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .req_lanes_i(req_lanes_i),
    .state_valid_i(state_valid_i), .state_ready_o(state_ready_o),
    .state_array_in(state_array_in), .lane_o(lane_o), .lane_valid_o(lane_valid_o),
    .lane_ready_i(lane_ready_i), .lane_last_o(lane_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] lane_val(int b, int x, int y);
    return 64'(b) * 64'd256 + 64'(10 * y + x);
  endfunction

  task automatic load_state(int b);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        state_array_in[x][y] = lane_val(b, x, y);
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // rdy_mode 0: ready always high; 1: ready pattern 1,0,0 repeating
  task automatic run_request(int req, int rdy_mode, bit poke_start, bit valid_with_start);
    int blk = 0;
    int rises = 0;
    int dones = 0;
    bit pend = 0;
    bit stalled = 0;
    bit prev_rdy_o = 0;
    bit rdy;
    logic [63:0] held = '0;
    logic [63:0] exp;
    for (int k = 0; k < req; k++) begin
      int i;
      i = k % RATE;
      q.push_back(lane_val(k / RATE, i % 5, i / 5));
    end
    start_i = 1'b1;
    req_lanes_i = LEN_W'(req);
    lane_ready_i = 1'b0;
    if (valid_with_start) begin
      state_valid_i = 1'b1;
      load_state(170);
    end else begin
      state_valid_i = 1'b0;
      load_state(0);
    end
    @(negedge clk);
    start_i = 1'b0;
    req_lanes_i = '0;
    load_state(0);
    state_valid_i = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      start_i = 1'b0;
      if (pend) begin
        blk++;
        load_state(blk);
        pend = 0;
      end
      if (done_o) begin
        dones++;
        break;
      end
      if (state_ready_o && !prev_rdy_o) rises++;
      prev_rdy_o = state_ready_o;
      if (state_ready_o) check("gap_valid_low", {63'd0, lane_valid_o}, 64'd0);
      if (stalled) begin
        check("stall_valid", {63'd0, lane_valid_o}, 64'd1);
        check("stall_lane", lane_o, held);
      end
      rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      stalled = 0;
      if (lane_valid_o) begin
        if (rdy) begin
          if (q.size() == 0) begin
            check("extra_lane", lane_o, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp = q.pop_front();
            check("lane", lane_o, exp);
            check("lane_last", {63'd0, lane_last_o}, {63'd0, q.size() == 0});
            last_lane = exp;
          end
        end else begin
          stalled = 1;
          held = lane_o;
        end
        if (poke_start) begin
          start_i = 1'b1;
          req_lanes_i = LEN_W'(3);
        end
      end
      lane_ready_i = rdy;
      if (state_ready_o && state_valid_i) pend = 1;
      @(negedge clk);
    end
    start_i = 1'b0;
    lane_ready_i = 1'b0;
    state_valid_i = 1'b0;
    check("done_seen", 64'(dones), 64'd1);
    check("busy_at_done", {63'd0, busy_o}, 64'd0);
    check("queue_drained", 64'(q.size()), 64'd0);
    check("state_ready_rises", 64'(rises), 64'((req + RATE - 1) / RATE));
    q.delete();
    @(negedge clk);
    check("done_single_pulse", {63'd0, done_o}, 64'd0);
    check("idle_valid_low", {63'd0, lane_valid_o}, 64'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start_i = 1'b0;
    req_lanes_i = '0;
    state_valid_i = 1'b0;
    lane_ready_i = 1'b0;
    load_state(0);
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, state_ready_o}, 64'd0);
    check("rst_valid", {63'd0, lane_valid_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_lane", lane_o, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset asserted after two lanes of a 5-lane request
    start_i = 1'b1;
    req_lanes_i = LEN_W'(5);
    @(negedge clk);
    start_i = 1'b0;
    req_lanes_i = '0;
    state_valid_i = 1'b1;
    lane_ready_i = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 50 && n < 2; cyc++) begin
      @(negedge clk);
      if (lane_valid_o) n++;
    end
    check("midstream_lanes_seen", 64'(n), 64'd2);
    @(posedge clk);
    #2;
    check("pre_rst_valid", {63'd0, lane_valid_o}, 64'd1);
    check("pre_rst_lane", lane_o, lane_val(0, 2, 0));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, lane_valid_o}, 64'd0);
    check("async_rst_last", {63'd0, lane_last_o}, 64'd0);
    check("async_rst_busy", {63'd0, busy_o}, 64'd0);
    check("async_rst_ready", {63'd0, state_ready_o}, 64'd0);
    check("async_rst_lane", lane_o, 64'd0);
    state_valid_i = 1'b0;
    lane_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {63'd0, busy_o}, 64'd0);

    run_request(5, 0, 0, 0);
    run_request(17, 1, 1, 0);
    run_request(40, 0, 0, 0);
    run_request(2, 0, 0, 1);

`ifdef SQUEEZE_ZEROIZE_EN
    check("zeroize_lane", lane_o, 64'd0);
    check("zeroize_cap", {63'd0, |dut.cap}, 64'd0);
`else
    check("hold_lane", lane_o, last_lane);
`endif

    // zero-length request
    start_i = 1'b1;
    req_lanes_i = '0;
    state_valid_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("zero_done", {63'd0, done_o}, 64'd1);
    check("zero_ready", {63'd0, state_ready_o}, 64'd0);
    check("zero_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    check("zero_done_fall", {63'd0, done_o}, 64'd0);
    check("zero_ready_still", {63'd0, state_ready_o}, 64'd0);
    state_valid_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
